// File: rtl/toggle_event_decoder_if.sv
// Consumer-side handshake of the toggle-event decoder: pending count plus valid/ready.
// The decoder drives the master modport; the event consumer uses the slave modport.
interface toggle_event_decoder_if #(
    parameter int PEND_DEPTH = 4
);
    logic                              ev_valid;
    logic                              ev_ready;
    logic [$clog2(PEND_DEPTH+1)-1:0]   pend_count;

    modport master (
        output ev_valid,
        output pend_count,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  pend_count,
        output ev_ready
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// Recovers events from a remote toggle line: synchronizes it, pulses once per transition,
// counts events and queues them for a valid/ready consumer. Define TGL_DEC_SYNC3_EN for a 3-flop synchronizer.
module toggle_event_decoder #(
    parameter int CNT_W      = 8,
    parameter int PEND_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tgl_in,
    output logic                      ev_pulse,
    output logic [CNT_W-1:0]          ev_count,
    output logic                      overflow,
    input  logic                      clr_ovf,
    toggle_event_decoder_if.master    bus
);

    localparam int            PW       = $clog2(PEND_DEPTH + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(PEND_DEPTH);

    logic          s1;
    logic          s2;
    logic          prev;
    logic          det;
    logic [PW-1:0] pend_q;
    logic [PW-1:0] pend_next;
    logic          ovf_set;
    logic          inc;
    logic          dec;

`ifdef TGL_DEC_SYNC3_EN
    logic          s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= tgl_in;
            s2   <= s1;
            s3   <= s2;
            prev <= s3;
        end
    end

    assign det = s3 ^ prev;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= tgl_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign det = s2 ^ prev;
`endif

    assign inc          = ev_pulse;
    assign dec          = bus.ev_valid && bus.ev_ready;
    assign bus.ev_valid = (pend_q != '0);
    assign bus.pend_count = pend_q;

    // A simultaneous arrival and acceptance leaves the queue unchanged, even when full.
    always_comb begin
        pend_next = pend_q;
        ovf_set   = 1'b0;
        if (inc && !dec) begin
            if (pend_q < PEND_MAX) begin
                pend_next = pend_q + PW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (!inc && dec) begin
            pend_next = pend_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_pulse <= 1'b0;
            ev_count <= '0;
            pend_q   <= '0;
            overflow <= 1'b0;
        end else begin
            ev_pulse <= det;
            pend_q   <= pend_next;
            if (ev_pulse) begin
                ev_count <= ev_count + CNT_W'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
